// File: rtl/umi_regif_pipe.sv
// Pipelined UMI device-side register interface: decodes UMI requests into register
// strobes and returns responses through a credit-managed response FIFO.
module umi_regif_pipe #(
  parameter int unsigned AW        = 64,
  parameter int unsigned CW        = 32,
  parameter int unsigned DW        = 256,
  parameter int unsigned RW        = 64,
  parameter int unsigned GRPOFFSET = 24,
  parameter int unsigned GRPAW     = 4,
  parameter int unsigned GRPID     = 0,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RDLAT     = 1,
  parameter int unsigned ERRRESP   = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev_req_valid,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  input  logic          udev_resp_ready,
  output logic [AW-1:0] reg_addr,
  output logic          reg_write,
  output logic          reg_read,
  output logic [4:0]    reg_opcode,
  output logic [2:0]    reg_size,
  output logic [7:0]    reg_len,
  output logic [RW-1:0] reg_wrdata,
  input  logic [RW-1:0] reg_rddata
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned NREP = DW / RW;
  localparam int unsigned RWB  = RW / 8;
  localparam logic [4:0]  REQ_READ   = 5'h01;
  localparam logic [4:0]  REQ_WRITE  = 5'h03;
  localparam logic [4:0]  REQ_POSTED = 5'h05;
  localparam logic [4:0]  RESP_READ  = 5'h02;
  localparam logic [4:0]  RESP_WRITE = 5'h04;
  localparam logic        ERR_EN     = (ERRRESP != 0);

  logic          ready_q;
  logic          acc, is_read, is_write, is_posted;
  logic          match, fits, ok, respond;
  logic [16:0]   nbytes;
  logic [1:0]    err;
  logic [CW-1:0] hdr_cmd;

  assign reg_opcode = udev_req_cmd[4:0];
  assign reg_size   = udev_req_cmd[7:5];
  assign reg_len    = udev_req_cmd[15:8];
  assign reg_addr   = udev_req_dstaddr;
  assign reg_wrdata = udev_req_data[RW-1:0];

  assign is_read   = (reg_opcode == REQ_READ);
  assign is_write  = (reg_opcode == REQ_WRITE);
  assign is_posted = (reg_opcode == REQ_POSTED);

  // Byte count of the request must fit in one register
  assign nbytes = (17'(reg_len) + 17'd1) << reg_size;
  assign fits   = (nbytes <= 17'(RWB));

  if (GRPAW == 0) begin : g_nogrp
    assign match = 1'b1;
  end else begin : g_grp
    assign match = (udev_req_dstaddr[GRPOFFSET +: GRPAW] == GRPAW'(GRPID));
  end

  if (DW > RW) begin : g_unused
    logic unused_data;
    assign unused_data = ^udev_req_data[DW-1:RW];
  end

  assign ok        = match & fits;
  assign acc       = udev_req_valid & ready_q;
  assign reg_read  = acc & is_read & ok;
  assign reg_write = acc & (is_write | is_posted) & ok;
  assign respond   = acc & ~is_posted & (match | ERR_EN);
  assign err       = (ok & (is_read | is_write)) ? 2'b00 : 2'b10;

  always_comb begin
    hdr_cmd        = udev_req_cmd;
    hdr_cmd[4:0]   = is_write ? RESP_WRITE : RESP_READ;
    hdr_cmd[26:25] = err;
  end

  // Read-latency stage: header waits here until reg_rddata is valid
  logic          st_valid, st_rd, pipe_next;
  logic [CW-1:0] st_cmd;
  logic [AW-1:0] st_dst, st_src;

  if (RDLAT == 0) begin : g_lat0
    assign st_valid  = respond;
    assign st_rd     = reg_read;
    assign st_cmd    = hdr_cmd;
    assign st_dst    = udev_req_srcaddr;
    assign st_src    = udev_req_dstaddr;
    assign pipe_next = 1'b0;
  end else begin : g_lat1
    logic          p_valid, p_rd;
    logic [CW-1:0] p_cmd;
    logic [AW-1:0] p_dst, p_src;

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        p_valid <= 1'b0;
        p_rd    <= 1'b0;
        p_cmd   <= '0;
        p_dst   <= '0;
        p_src   <= '0;
      end else begin
        p_valid <= respond;
        p_rd    <= reg_read;
        if (respond) begin
          p_cmd <= hdr_cmd;
          p_dst <= udev_req_srcaddr;
          p_src <= udev_req_dstaddr;
        end
      end
    end

    assign st_valid  = p_valid;
    assign st_rd     = p_rd;
    assign st_cmd    = p_cmd;
    assign st_dst    = p_dst;
    assign st_src    = p_src;
    assign pipe_next = respond;
  end

  // Response FIFO
  logic [CW-1:0]   cmd_mem  [DEPTH];
  logic [AW-1:0]   dst_mem  [DEPTH];
  logic [AW-1:0]   src_mem  [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_next;
  logic [CNTW:0]   used_next;
  logic            push, pop;
  logic [DW-1:0]   push_data;

  assign push            = st_valid;
  assign push_data       = st_rd ? {NREP{reg_rddata}} : '0;
  assign udev_resp_valid = (count != '0);
  assign pop             = udev_resp_valid & udev_resp_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNTW'(1);
    else if (!push && pop) count_next = count - CNTW'(1);
  end

  // Credits cover queued entries plus responses still in the latency stage
  assign used_next = (CNTW+1)'(count_next) + (CNTW+1)'(pipe_next);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cmd_mem[i]  <= '0;
        dst_mem[i]  <= '0;
        src_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        cmd_mem[wr_ptr]  <= st_cmd;
        dst_mem[wr_ptr]  <= st_dst;
        src_mem[wr_ptr]  <= st_src;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count   <= count_next;
      ready_q <= (used_next < (CNTW+1)'(DEPTH));
    end
  end

  assign udev_req_ready    = ready_q;
  assign udev_resp_cmd     = cmd_mem[rd_ptr];
  assign udev_resp_dstaddr = dst_mem[rd_ptr];
  assign udev_resp_srcaddr = src_mem[rd_ptr];
  assign udev_resp_data    = data_mem[rd_ptr];

endmodule

// File: tb/tb_umi_regif_pipe.sv
// Self-checking bench for umi_regif_pipe: vector table, directed corner sequences and
// randomized traffic against a transaction-level response-queue model.
module tb_umi_regif_pipe;

  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          valid = 1'b0, rready = 1'b1;
  logic [31:0]   cmd = '0;
  logic [63:0]   dst = '0, src = '0;
  logic [255:0]  data = '0;
  logic          ready, rvalid;
  logic [31:0]   rcmd;
  logic [63:0]   rdst, rsrc;
  logic [255:0]  rdata;
  logic [63:0]   reg_addr, reg_wrdata, reg_rddata;
  logic          reg_write, reg_read;
  logic [4:0]    reg_opcode;
  logic [2:0]    reg_size;
  logic [7:0]    reg_len;
  logic [63:0]   rd_addr_q = '0;

  // Second instance: no error responses, zero read latency
  logic          valid2 = 1'b0, rready2 = 1'b1;
  logic          ready2, rvalid2, reg_read2;
  logic [31:0]   rcmd2;
  logic [255:0]  rdata2;
  logic [63:0]   reg_addr2, rddata2;
  logic [63:0]   unused_rsrc2, unused_wrdata2;
  logic          unused_write2;
  logic [4:0]    unused_opc2;
  logic [2:0]    unused_size2;
  logic [7:0]    unused_len2;
  logic [63:0]   unused_rdst2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  umi_regif_pipe u_dut (
    .clk(clk), .nreset(nreset),
    .udev_req_valid(valid), .udev_req_cmd(cmd), .udev_req_dstaddr(dst),
    .udev_req_srcaddr(src), .udev_req_data(data), .udev_req_ready(ready),
    .udev_resp_valid(rvalid), .udev_resp_cmd(rcmd), .udev_resp_dstaddr(rdst),
    .udev_resp_srcaddr(rsrc), .udev_resp_data(rdata), .udev_resp_ready(rready),
    .reg_addr(reg_addr), .reg_write(reg_write), .reg_read(reg_read),
    .reg_opcode(reg_opcode), .reg_size(reg_size), .reg_len(reg_len),
    .reg_wrdata(reg_wrdata), .reg_rddata(reg_rddata));

  umi_regif_pipe #(.RDLAT(0), .ERRRESP(0)) u_dut2 (
    .clk(clk), .nreset(nreset),
    .udev_req_valid(valid2), .udev_req_cmd(cmd), .udev_req_dstaddr(dst),
    .udev_req_srcaddr(src), .udev_req_data(data), .udev_req_ready(ready2),
    .udev_resp_valid(rvalid2), .udev_resp_cmd(rcmd2), .udev_resp_dstaddr(unused_rdst2),
    .udev_resp_srcaddr(unused_rsrc2), .udev_resp_data(rdata2), .udev_resp_ready(rready2),
    .reg_addr(reg_addr2), .reg_write(unused_write2), .reg_read(reg_read2),
    .reg_opcode(unused_opc2), .reg_size(unused_size2), .reg_len(unused_len2),
    .reg_wrdata(unused_wrdata2), .reg_rddata(rddata2));

  function automatic logic [63:0] rdfn(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]};
  endfunction

  function automatic logic [31:0] mk_cmd(input logic [4:0] o, input logic [2:0] s,
                                         input logic [7:0] l);
    return {5'h05, 2'b01, 9'h012, l, s, o};
  endfunction

  function automatic logic [63:0] mk_dst(input logic [3:0] g, input logic [23:0] off);
    return {32'h0, 4'h0, g, off};
  endfunction

  // Register file: read data appears one cycle after the strobe
  always @(posedge clk) if (reg_read) rd_addr_q <= reg_addr;
  assign reg_rddata = rdfn(rd_addr_q);
  assign rddata2    = rdfn(reg_addr2);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] c, input logic [63:0] d,
                       input logic [63:0] s, input logic [255:0] dat, input logic rr);
    @(negedge clk);
    valid = v; cmd = c; dst = d; src = s; data = dat; rready = rr;
    #1;
  endtask

  task automatic idle(input logic rr);
    @(negedge clk);
    valid = 1'b0; rready = rr;
    #1;
  endtask

  // Reference model: ordered queue of expected responses and an outstanding count
  typedef struct {
    logic [31:0]  cmd;
    logic [63:0]  dst, src;
    logic [255:0] data;
  } resp_t;
  resp_t expq[$];

  initial begin : model
    logic m_init;
    int   outst;
    logic exp_rdy, acc, is_rd, is_wr, is_pw, ok;
    int   nb;
    resp_t e;
    m_init = 1'b0;
    outst  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!nreset) begin
        chk("rst_ready", ready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_strobe", {reg_read, reg_write}, 2'b00);
        expq.delete();
        outst  = 0;
        m_init = 1'b0;
      end else begin
        exp_rdy = m_init && (outst < DEPTH);
        chk("ready", ready, exp_rdy);
        acc   = valid && exp_rdy;
        is_rd = (cmd[4:0] == 5'h01);
        is_wr = (cmd[4:0] == 5'h03);
        is_pw = (cmd[4:0] == 5'h05);
        nb    = (int'(cmd[15:8]) + 1) * (1 << cmd[7:5]);
        ok    = (dst[27:24] == 4'd0) && (nb <= 8);
        chk("reg_read", reg_read, acc && is_rd && ok);
        chk("reg_write", reg_write, acc && (is_wr || is_pw) && ok);
        if (valid) begin
          chk("reg_addr", reg_addr, dst);
          chk("reg_fields", {reg_len, reg_size, reg_opcode}, cmd[15:0]);
          chk("reg_wrdata", reg_wrdata, data[63:0]);
        end
        if (rvalid) begin
          chk("resp_expected", expq.size() != 0, 1'b1);
          if (expq.size() != 0) begin
            chk("resp_cmd", rcmd, expq[0].cmd);
            chk("resp_dst", rdst, expq[0].dst);
            chk("resp_src", rsrc, expq[0].src);
            chk("resp_data", rdata, expq[0].data);
            if (rready) begin
              void'(expq.pop_front());
              outst--;
            end
          end
        end
        if (acc && !is_pw) begin
          e.cmd        = cmd;
          e.cmd[4:0]   = is_wr ? 5'h04 : 5'h02;
          e.cmd[26:25] = (ok && (is_rd || is_wr)) ? 2'b00 : 2'b10;
          e.dst        = src;
          e.src        = dst;
          e.data       = (is_rd && ok) ? {4{rdfn(dst)}} : 256'd0;
          expq.push_back(e);
          outst++;
        end
        m_init = 1'b1;
      end
    end
  end

  typedef struct {
    logic [4:0] opc;
    logic [2:0] size;
    logic [7:0] len;
    logic [3:0] grp;
    logic       e_rd, e_wr, e_resp;
    logic [1:0] e_err;
    logic [4:0] e_opc;
  } vec_t;

  vec_t vecs [12] = '{
    '{5'h01, 3'd3, 8'd0, 4'd0, 1'b1, 1'b0, 1'b1, 2'b00, 5'h02},
    '{5'h03, 3'd3, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1, 2'b00, 5'h04},
    '{5'h05, 3'd2, 8'd1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'h00},
    '{5'h01, 3'd3, 8'd0, 4'd1, 1'b0, 1'b0, 1'b1, 2'b10, 5'h02},
    '{5'h01, 3'd3, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 5'h02},
    '{5'h09, 3'd2, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 5'h02},
    '{5'h03, 3'd0, 8'd7, 4'd0, 1'b0, 1'b1, 1'b1, 2'b00, 5'h04},
    '{5'h03, 3'd0, 8'd8, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 5'h04},
    '{5'h05, 3'd3, 8'd0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 5'h00},
    '{5'h01, 3'd1, 8'd3, 4'd0, 1'b1, 1'b0, 1'b1, 2'b00, 5'h02},
    '{5'h01, 3'd7, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 5'h02},
    '{5'h07, 3'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 5'h02}
  };

  logic [4:0] opcs [7] = '{5'h01, 5'h03, 5'h05, 5'h09, 5'h07, 5'h01, 5'h03};

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          acc_cnt, got;
    logic        seen;
    logic [63:0] srcq[$];

    repeat (3) @(negedge clk);
    nreset = 1'b1;
    idle(1'b1);
    idle(1'b1);
    chk("init_ready", ready, 1'b1);

    // Single-request vector table
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, mk_cmd(vecs[i].opc, vecs[i].size, vecs[i].len),
            mk_dst(vecs[i].grp, 24'(i * 8)), 64'h9000 + 64'(i), {4{64'h1111_2222_3333_0000 + 64'(i)}}, 1'b1);
      chk($sformatf("v%0d_read", i), reg_read, vecs[i].e_rd);
      chk($sformatf("v%0d_write", i), reg_write, vecs[i].e_wr);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idle(1'b1);
        if (rvalid && !seen) begin
          seen = 1'b1;
          chk($sformatf("v%0d_err", i), rcmd[26:25], vecs[i].e_err);
          chk($sformatf("v%0d_opc", i), rcmd[4:0], vecs[i].e_opc);
        end
      end
      chk($sformatf("v%0d_resp", i), seen, vecs[i].e_resp);
    end

    // Back-to-back reads: responses two cycles after each accept
    drive(1'b1, mk_cmd(5'h01, 3'd3, 8'd0), 64'h0, 64'hA0, '0, 1'b1);
    chk("b2b_ready", ready, 1'b1);
    drive(1'b1, mk_cmd(5'h01, 3'd3, 8'd0), 64'h8, 64'hA1, '0, 1'b1);
    chk("b2b_c2_valid", rvalid, 1'b0);
    drive(1'b1, mk_cmd(5'h01, 3'd3, 8'd0), 64'h10, 64'hA2, '0, 1'b1);
    chk("b2b_c3_valid", rvalid, 1'b1);
    chk("b2b_c3_data", rdata, {4{rdfn(64'h0)}});
    chk("b2b_c3_dst", rdst, 64'hA0);
    chk("b2b_c3_err", rcmd[26:25], 2'b00);
    idle(1'b1);
    chk("b2b_c4_data", rdata, {4{rdfn(64'h8)}});
    chk("b2b_c4_dst", rdst, 64'hA1);
    idle(1'b1);
    chk("b2b_c5_data", rdata, {4{rdfn(64'h10)}});
    chk("b2b_c5_dst", rdst, 64'hA2);
    idle(1'b1);
    chk("b2b_c6_valid", rvalid, 1'b0);

    // Credit exhaustion with response backpressure
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk_cmd(5'h03, 3'd3, 8'd0), 64'h100, 64'hB0 + 64'(i), 256'(i), 1'b0);
      if (ready) begin
        srcq.push_back(64'hB0 + 64'(i));
        acc_cnt++;
      end
    end
    chk("full_accepts", acc_cnt, 4);
    chk("full_ready", ready, 1'b0);
    idle(1'b1);
    chk("full_pop_valid", rvalid, 1'b1);
    chk("full_pop_opc", rcmd[4:0], 5'h04);
    if (srcq.size() > 0) chk("full_pop_dst", rdst, srcq[0]);
    idle(1'b0);
    chk("full_ready_back", ready, 1'b1);
    got = 0;
    for (int k = 0; k < 6 && got < 3; k++) begin
      idle(1'b1);
      if (rvalid) begin
        chk("drain_opc", rcmd[4:0], 5'h04);
        if (srcq.size() > got + 1) chk("drain_order", rdst, srcq[got+1]);
        got++;
      end
    end
    chk("drain_count", got, 3);

    // No-error-response instance: mismatch swallowed, zero-latency read
    @(negedge clk);
    valid = 1'b0; valid2 = 1'b1; cmd = mk_cmd(5'h01, 3'd3, 8'd0); dst = mk_dst(4'd1, 24'h40);
    #1;
    chk("d2_ready", ready2, 1'b1);
    chk("d2_mis_read", reg_read2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); valid2 = 1'b0; #1;
      chk("d2_mis_noresp", rvalid2, 1'b0);
    end
    @(negedge clk);
    valid2 = 1'b1; dst = mk_dst(4'd0, 24'h48);
    #1;
    chk("d2_read", reg_read2, 1'b1);
    @(negedge clk); valid2 = 1'b0; #1;
    chk("d2_lat_valid", rvalid2, 1'b1);
    chk("d2_data", rdata2, {4{rdfn(mk_dst(4'd0, 24'h48))}});
    chk("d2_cmd", {rcmd2[26:25], rcmd2[4:0]}, {2'b00, 5'h02});
    @(negedge clk); #1;
    chk("d2_done", rvalid2, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0]  r;
      logic [255:0] dat;
      r = $urandom;
      for (int w = 0; w < 8; w++) dat[w*32 +: 32] = $urandom;
      drive($urandom_range(0, 3) != 0,
            {r[31:16], 8'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), opcs[$urandom_range(0, 6)]},
            mk_dst(($urandom_range(0, 7) == 0) ? 4'd1 : 4'd0, 24'($urandom_range(0, 4095) * 8)),
            {$urandom, $urandom}, dat, $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 30; k++) begin
      idle(1'b1);
      if (expq.size() == 0 && !rvalid) break;
    end
    chk("rand_drained", expq.size(), 0);

    // Reset with queued responses
    for (int i = 0; i < 3; i++)
      drive(1'b1, mk_cmd(5'h01, 3'd3, 8'd0), 64'h20 + 64'(8 * i), 64'hC0 + 64'(i), '0, 1'b0);
    repeat (3) idle(1'b0);
    chk("rst_queued", rvalid, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nreset = 1'b0; valid = 1'b1; rready = 1'b1;
      #1;
      chk("rst_mid_ready", ready, 1'b0);
      chk("rst_mid_valid", rvalid, 1'b0);
      chk("rst_mid_read", reg_read, 1'b0);
    end
    @(negedge clk);
    nreset = 1'b1; valid = 1'b0;
    #1;
    chk("rst_rel_ready", ready, 1'b0);
    idle(1'b1);
    chk("rst_rel_ready1", ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("rst_no_stale", rvalid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
